apb_master_arbiter: RTL and testbench

- APB master that shares one APB bus among NUM_REQ local requesters.
- Uses round-robin arbitration and generates the APB SETUP/ACCESS phase sequence.
- Aborts transfers whose slave never asserts ready, using a programmable timeout.
- Sits between on-chip requesters and the APB slave port that the testbench slave interface drives.

---
 rtl/apb_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/apb_master_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    localparam int PROT_W  = 3;
    localparam int MAX_REQ = 8;

    // One-hot vector with bit idx set; callers size-cast to their own width.
    function automatic logic [MAX_REQ-1:0] onehot(input int idx);
        onehot = MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first eligible requester at or after ptr wins.
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         mask,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         win_onehot,
    output logic [$clog2(NUM_REQ)-1:0] win_idx,
    output logic                       win_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] elig;

    assign elig = req & ~mask;

    // Scan from the pointer, wrapping around, and keep the first hit.
    always_comb begin
        int cand;
        // NOTE: every value this block writes is defaulted first, so no latch is inferred.
        cand      = 0;
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!win_valid && elig[cand]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    assign win_onehot = win_valid ? NUM_REQ'(onehot(int'(win_idx))) : '0;

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by NUM_REQ requesters: round-robin grant, SETUP/ACCESS
// sequencing and an optional ACCESS-phase timeout abort.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = `APB_ADDR_WIDTH,
    parameter int DATA_W  = `APB_DATA_WIDTH,
    parameter int TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0]  req_strb,
    input  logic [NUM_REQ*PROT_W-1:0]    req_prot,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_error,
    output logic                         rsp_timeout,
    output logic [ADDR_W-1:0]            addr,
    output logic                         sel,
    output logic                         enable,
    output logic                         write,
    output logic [DATA_W-1:0]            wdata,
    output logic [DATA_W/8-1:0]          strb,
    output logic [PROT_W-1:0]            prot,
    input  logic [DATA_W-1:0]            rdata,
    input  logic                         ready,
    input  logic                         slave_error
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Counter value at which one more ready-low edge reaches TIMEOUT.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   cur_q, cur_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               write_q, write_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [STRB_W-1:0]  strb_q, strb_d;
    logic [PROT_W-1:0]  prot_q, prot_d;
    logic               sel_q, sel_d;
    logic               enable_q, enable_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_error_q, rsp_error_d;
    logic               rsp_timeout_q, rsp_timeout_d;

    logic [NUM_REQ-1:0] arb_onehot;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;

    // The requester being completed this cycle sits out one arbitration round.
    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arbiter (
        .req        (req),
        .mask       (done_q),
        .ptr        (ptr_q),
        .win_onehot (arb_onehot),
        .win_idx    (arb_idx),
        .win_valid  (arb_valid)
    );

    // Next-state, bus-field and response logic for the IDLE/SETUP/ACCESS sequence.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cur_d         = cur_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        write_d       = write_q;
        wdata_d       = wdata_q;
        strb_d        = strb_q;
        prot_d        = prot_q;
        sel_d         = sel_q;
        enable_d      = enable_q;
        gnt_d         = '0;
        done_d        = '0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                sel_d    = 1'b0;
                enable_d = 1'b0;
                if (arb_valid) begin
                    cur_d    = arb_idx;
                    addr_d   = req_addr[arb_idx*ADDR_W +: ADDR_W];
                    write_d  = req_write[arb_idx];
                    wdata_d  = req_wdata[arb_idx*DATA_W +: DATA_W];
                    strb_d   = req_strb[arb_idx*STRB_W +: STRB_W];
                    prot_d   = req_prot[arb_idx*PROT_W +: PROT_W];
                    gnt_d    = arb_onehot;
                    ptr_d    = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    cnt_d    = '0;
                    sel_d    = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                enable_d = 1'b1;
                state_d  = ACCESS;
            end
            ACCESS: begin
                if (ready) begin
                    done_d        = NUM_REQ'(onehot(int'(cur_q)));
                    rsp_rdata_d   = write_q ? '0 : rdata;
                    rsp_error_d   = slave_error;
                    rsp_timeout_d = 1'b0;
                    sel_d         = 1'b0;
                    enable_d      = 1'b0;
                    state_d       = IDLE;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    done_d        = NUM_REQ'(onehot(int'(cur_q)));
                    rsp_rdata_d   = '0;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    sel_d         = 1'b0;
                    enable_d      = 1'b0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops the bus at once and discards any transfer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            cur_q         <= '0;
            cnt_q         <= '0;
            addr_q        <= '0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            strb_q        <= '0;
            prot_q        <= '0;
            sel_q         <= 1'b0;
            enable_q      <= 1'b0;
            gnt_q         <= '0;
            done_q        <= '0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cur_q         <= cur_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            write_q       <= write_d;
            wdata_q       <= wdata_d;
            strb_q        <= strb_d;
            prot_q        <= prot_d;
            sel_q         <= sel_d;
            enable_q      <= enable_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;
    assign addr        = addr_q;
    assign sel         = sel_q;
    assign enable      = enable_q;
    assign write       = write_q;
    assign wdata       = wdata_q;
    assign strb        = strb_q;
    assign prot        = prot_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench: stimulus pushes predicted grants/responses, a monitor pops and compares.
module tb_apb_master_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = DATA_W / 8;
    localparam int TIMEOUT = 16;
    localparam int MAXJ    = 8;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
        logic [2:0]        prot;
        int                waits;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } job_t;

    typedef struct {
        int                r;
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              to;
        int                lat;
    } rsp_t;

    logic clk = 1'b0;
    logic rstn;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ-1:0]          req_write;
    logic [NUM_REQ*DATA_W-1:0]   req_wdata;
    logic [NUM_REQ*STRB_W-1:0]   req_strb;
    logic [NUM_REQ*3-1:0]        req_prot;
    logic [NUM_REQ-1:0]          gnt, done;
    logic [DATA_W-1:0]           rsp_rdata;
    logic                        rsp_error, rsp_timeout;
    logic [ADDR_W-1:0]           addr;
    logic                        sel, enable, write;
    logic [DATA_W-1:0]           wdata;
    logic [STRB_W-1:0]           strb;
    logic [2:0]                  prot;
    logic [DATA_W-1:0]           rdata;
    logic                        ready, slave_error;

    logic              r_req   [NUM_REQ];
    logic [ADDR_W-1:0] r_addr  [NUM_REQ];
    logic              r_write [NUM_REQ];
    logic [DATA_W-1:0] r_wdata [NUM_REQ];
    logic [STRB_W-1:0] r_strb  [NUM_REQ];
    logic [2:0]        r_prot  [NUM_REQ];

    job_t jobs [NUM_REQ][MAXJ];
    int   jcnt [NUM_REQ];
    job_t cur_job [NUM_REQ];
    int   gnt_cyc [NUM_REQ];
    int   exp_gnt [$];
    rsp_t exp_rsp [$];
    int   m_ptr;
    int   cur_owner;
    int   active;
    int   cyc;
    int   compared;
    int   mismatched;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    apb_master_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req(req), .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
        .req_strb(req_strb), .req_prot(req_prot),
        .gnt(gnt), .done(done), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .rsp_timeout(rsp_timeout),
        .addr(addr), .sel(sel), .enable(enable), .write(write), .wdata(wdata),
        .strb(strb), .prot(prot), .rdata(rdata), .ready(ready), .slave_error(slave_error)
    );

    always_comb begin
        req = '0; req_addr = '0; req_write = '0; req_wdata = '0; req_strb = '0; req_prot = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            req[r]                       = r_req[r];
            req_addr[r*ADDR_W +: ADDR_W] = r_addr[r];
            req_write[r]                 = r_write[r];
            req_wdata[r*DATA_W +: DATA_W] = r_wdata[r];
            req_strb[r*STRB_W +: STRB_W] = r_strb[r];
            req_prot[r*3 +: 3]           = r_prot[r];
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic job_t mk_job(input logic [ADDR_W-1:0] a, input logic w,
                                    input logic [DATA_W-1:0] wd, input logic [STRB_W-1:0] s,
                                    input logic [2:0] p, input int waits, input logic err,
                                    input logic [DATA_W-1:0] rd);
        job_t j;
        j.addr = a; j.write = w; j.wdata = wd; j.strb = s; j.prot = p;
        j.waits = waits; j.err = err; j.rdata = rd;
        return j;
    endfunction

    function automatic job_t rand_job();
        int w;
        w = ($urandom_range(0, 7) == 0) ? TIMEOUT + $urandom_range(0, 4) : $urandom_range(0, 4);
        return mk_job($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
                      w, ($urandom_range(0, 3) == 0), $urandom);
    endfunction

    task automatic drive(input int r, input job_t j);
        r_addr[r] = j.addr; r_write[r] = j.write; r_wdata[r] = j.wdata;
        r_strb[r] = j.strb; r_prot[r] = j.prot;
    endtask

    // Reference: strict rotation from the pointer over requesters with work left.
    task automatic predict();
        int rem [NUM_REQ];
        int idx [NUM_REQ];
        int total;
        total = 0;
        for (int r = 0; r < NUM_REQ; r++) begin rem[r] = jcnt[r]; idx[r] = 0; total += jcnt[r]; end
        for (int t = 0; t < total; t++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int c;
                c = (m_ptr + k) % NUM_REQ;
                if (rem[c] > 0) begin
                    job_t j;
                    rsp_t e;
                    j = jobs[c][idx[c]];
                    e.r     = c;
                    e.to    = (j.waits >= TIMEOUT);
                    e.rdata = (j.write || e.to) ? '0 : j.rdata;
                    e.err   = e.to || j.err;
                    e.lat   = 2 + (e.to ? TIMEOUT - 1 : j.waits);
                    exp_gnt.push_back(c);
                    exp_rsp.push_back(e);
                    rem[c]--; idx[c]++;
                    m_ptr = (c + 1) % NUM_REQ;
                    break;
                end
            end
        end
    endtask

    task automatic requester(input int r);
        for (int k = 0; k < jcnt[r]; k++) begin
            int n;
            cur_job[r] = jobs[r][k];
            drive(r, jobs[r][k]);
            r_req[r] = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!done[r] && n < 600);
            if (!done[r]) begin
                check("done_wait", 128'(done[r]), 128'(1));
                break;
            end
        end
        r_req[r] = 1'b0;
        active--;
    endtask

    task automatic run_batch();
        int n;
        predict();
        active = 0;
        for (int r = 0; r < NUM_REQ; r++) if (jcnt[r] > 0) active++;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (jcnt[r] > 0) begin
                automatic int rr = r;
                fork
                    requester(rr);
                join_none
            end
        end
        n = 0;
        while (active > 0 && n < 5000) begin @(negedge clk); n++; end
        if (active > 0) check("batch_wait", 128'(active), 128'(0));
        repeat (3) @(negedge clk);
    endtask

    // Monitor/scoreboard plus APB slave model, both evaluated away from the active edge.
    initial begin
        int acc;
        acc = 0; ready = 1'b0; slave_error = 1'b0; rdata = '0; cur_owner = 0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (gnt != '0) begin
                    if (exp_gnt.size() == 0) check("unexpected_gnt", 128'(gnt), 128'(0));
                    else begin
                        int e;
                        e = exp_gnt.pop_front();
                        check("gnt", 128'(gnt), 128'(1) << e);
                        check("setup_phase", 128'({sel, enable}), 128'(2'b10));
                        cur_owner  = e;
                        gnt_cyc[e] = cyc;
                    end
                end
                if (done != '0) begin
                    if (exp_rsp.size() == 0) check("unexpected_done", 128'(done), 128'(0));
                    else begin
                        rsp_t e;
                        e = exp_rsp.pop_front();
                        check("done", 128'(done), 128'(1) << e.r);
                        check("rsp_rdata", 128'(rsp_rdata), 128'(e.rdata));
                        check("rsp_error", 128'(rsp_error), 128'(e.err));
                        check("rsp_timeout", 128'(rsp_timeout), 128'(e.to));
                        check("done_bus_idle", 128'({sel, enable}), 128'(0));
                        check("latency", 128'(cyc - gnt_cyc[e.r]), 128'(e.lat));
                    end
                end
            end
            if (sel && enable) begin
                job_t j;
                j = cur_job[cur_owner];
                check("bus_fields", {addr, write, wdata, strb, prot},
                      {j.addr, j.write, j.wdata, j.strb, j.prot});
                ready       = (acc >= j.waits);
                slave_error = ready && j.err;
                rdata       = j.rdata;
                acc++;
            end else begin
                ready = 1'b0; slave_error = 1'b0; rdata = $urandom; acc = 0;
            end
        end
    end

    initial begin
        rstn = 1'b0; m_ptr = 0; compared = 0; mismatched = 0; active = 0;
        for (int r = 0; r < NUM_REQ; r++) begin
            r_req[r] = 1'b0; drive(r, mk_job('0, 1'b0, '0, '0, '0, 0, 1'b0, '0));
            cur_job[r] = mk_job('0, 1'b0, '0, '0, '0, 0, 1'b0, '0); gnt_cyc[r] = 0; jcnt[r] = 0;
        end
        repeat (3) @(negedge clk);
        #1;
        check("reset_ctrl", 128'({sel, enable, write, gnt, done, rsp_error, rsp_timeout}), 128'(0));
        check("reset_bus", {addr, wdata, strb, prot}, 128'(0));
        check("reset_rdata", 128'(rsp_rdata), 128'(0));
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Single write, zero wait states.
        jobs[0][0] = mk_job(32'h10, 1'b1, 32'hA5A5_A5A5, 4'hF, 3'd0, 0, 1'b0, 32'h1234_5678);
        jcnt = '{1, 0, 0, 0};
        run_batch();

        // Read with two wait states.
        jobs[2][0] = mk_job(32'h20, 1'b0, 32'h0, 4'h0, 3'd2, 2, 1'b0, 32'hDEAD_BEEF);
        jcnt = '{0, 0, 1, 0};
        run_batch();

        // Contention: everyone holds req for two transfers each.
        for (int r = 0; r < NUM_REQ; r++) for (int k = 0; k < 2; k++) jobs[r][k] = rand_job();
        for (int r = 0; r < NUM_REQ; r++) for (int k = 0; k < 2; k++) jobs[r][k].waits = k;
        jcnt = '{2, 2, 2, 2};
        run_batch();

        // Slave error on a read.
        jobs[3][0] = mk_job(32'h30, 1'b0, 32'h0, 4'h0, 3'd1, 1, 1'b1, 32'hCAFE_F00D);
        jcnt = '{0, 0, 0, 1};
        run_batch();

        // Slave never ready: timeout abort.
        jobs[1][0] = mk_job(32'h40, 1'b0, 32'h0, 4'h0, 3'd0, 40, 1'b0, 32'h5555_AAAA);
        jcnt = '{0, 1, 0, 0};
        run_batch();

        // Reset in the middle of an ACCESS wait state.
        begin
            int n;
            job_t j;
            j = mk_job(32'h50, 1'b0, 32'h0, 4'h0, 3'd0, 30, 1'b0, 32'h0BAD_0BAD);
            jcnt = '{0, 0, 0, 0};
            cur_job[2] = j;
            drive(2, j);
            exp_gnt.push_back(2);
            r_req[2] = 1'b1;
            n = 0;
            while (!(sel && enable) && n < 50) begin @(negedge clk); n++; end
            check("reset_reach_access", 128'(enable), 128'(1));
            repeat (2) @(negedge clk);
            #2 rstn = 1'b0;
            r_req[2] = 1'b0;
            #1;
            check("reset_async_bus", 128'({sel, enable}), 128'(0));
            m_ptr = 0;
            repeat (2) @(negedge clk);
            rstn = 1'b1;
            repeat (3) @(negedge clk);
            jobs[1][0] = rand_job(); jobs[1][0].waits = 1;
            jobs[3][0] = rand_job(); jobs[3][0].waits = 0;
            jcnt = '{0, 1, 0, 1};
            run_batch();
        end

        // Random batches.
        for (int b = 0; b < 8; b++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                jcnt[r] = $urandom_range(0, 3);
                for (int k = 0; k < MAXJ; k++) jobs[r][k] = rand_job();
            end
            run_batch();
        end

        check("gnt_queue_drained", 128'(exp_gnt.size()), 128'(0));
        check("rsp_queue_drained", 128'(exp_rsp.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
